// File: rtl/multicycle_controller_pkg.sv
// Shared types and encodings for the multi-cycle RV32 controller.
// Optional trap state is enabled by defining MULTICYCLE_CTRL_TRAP_EN.
package multicycle_controller_pkg;

    localparam int ALU_OP_W = 4;
    // Byte step the datapath adds to PC when PCSrc selects PC+PC_INC.
    localparam int PC_INC   = 4;

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_TRAP   = 3'd5
    } state_t;

    typedef enum logic [2:0] {
        CLS_R   = 3'd0,
        CLS_I   = 3'd1,
        CLS_LW  = 3'd2,
        CLS_SW  = 3'd3,
        CLS_BEQ = 3'd4,
        CLS_JAL = 3'd5,
        CLS_LUI = 3'd6,
        CLS_ILL = 3'd7
    } instr_cls_t;

    localparam logic [6:0] OP_R   = 7'h33;
    localparam logic [6:0] OP_I   = 7'h13;
    localparam logic [6:0] OP_LW  = 7'h03;
    localparam logic [6:0] OP_SW  = 7'h23;
    localparam logic [6:0] OP_BEQ = 7'h63;
    localparam logic [6:0] OP_JAL = 7'h6F;
    localparam logic [6:0] OP_LUI = 7'h37;

    localparam logic [ALU_OP_W-1:0] ALU_AND = 4'b0000;
    localparam logic [ALU_OP_W-1:0] ALU_OR  = 4'b0001;
    localparam logic [ALU_OP_W-1:0] ALU_ADD = 4'b0010;
    localparam logic [ALU_OP_W-1:0] ALU_XOR = 4'b0011;
    localparam logic [ALU_OP_W-1:0] ALU_SUB = 4'b0110;
    localparam logic [ALU_OP_W-1:0] ALU_SLT = 4'b0111;
    localparam logic [ALU_OP_W-1:0] ALU_SLL = 4'b1000;
    localparam logic [ALU_OP_W-1:0] ALU_SRL = 4'b1001;
    localparam logic [ALU_OP_W-1:0] ALU_SRA = 4'b1010;

    localparam logic [1:0] PCSRC_INC    = 2'b00;
    localparam logic [1:0] PCSRC_BRANCH = 2'b01;
    localparam logic [1:0] PCSRC_JAL    = 2'b10;

    localparam logic [1:0] WB_ALU = 2'b00;
    localparam logic [1:0] WB_MEM = 2'b01;
    localparam logic [1:0] WB_PC4 = 2'b10;
    localparam logic [1:0] WB_IMM = 2'b11;

    function automatic instr_cls_t classify(input logic [6:0] opcode);
        instr_cls_t cls;
        case (opcode)
            OP_R:    cls = CLS_R;
            OP_I:    cls = CLS_I;
            OP_LW:   cls = CLS_LW;
            OP_SW:   cls = CLS_SW;
            OP_BEQ:  cls = CLS_BEQ;
            OP_JAL:  cls = CLS_JAL;
            OP_LUI:  cls = CLS_LUI;
            default: cls = CLS_ILL;
        endcase
        return cls;
    endfunction

endpackage

// File: rtl/multicycle_controller_alu_decoder.sv
// Combinational ALU operation decode from instruction class, funct3 and funct7[5].
// Also flags funct combinations the datapath does not support.
module multicycle_controller_alu_decoder
    import multicycle_controller_pkg::*;
(
    input  logic [2:0] cls,
    input  logic [2:0] funct3,
    input  logic       funct7_b5,
    output logic [3:0] alu_ctrl,
    output logic       illegal_funct
);

    instr_cls_t cls_e;
    logic       is_r;

    assign cls_e = instr_cls_t'(cls);
    assign is_r  = (cls_e == CLS_R);

    always_comb begin
        alu_ctrl      = ALU_ADD;
        illegal_funct = 1'b0;
        case (cls_e)
            CLS_R, CLS_I: begin
                // funct7[5] only selects SUB/SRA; anywhere else it is an unsupported encoding
                case (funct3)
                    3'b000: alu_ctrl = (is_r && funct7_b5) ? ALU_SUB : ALU_ADD;
                    3'b001: begin
                        alu_ctrl      = ALU_SLL;
                        illegal_funct = funct7_b5;
                    end
                    3'b010: begin
                        alu_ctrl      = ALU_SLT;
                        illegal_funct = is_r && funct7_b5;
                    end
                    3'b011: illegal_funct = 1'b1;
                    3'b100: begin
                        alu_ctrl      = ALU_XOR;
                        illegal_funct = is_r && funct7_b5;
                    end
                    3'b101: alu_ctrl = funct7_b5 ? ALU_SRA : ALU_SRL;
                    3'b110: begin
                        alu_ctrl      = ALU_OR;
                        illegal_funct = is_r && funct7_b5;
                    end
                    default: begin
                        alu_ctrl      = ALU_AND;
                        illegal_funct = is_r && funct7_b5;
                    end
                endcase
            end
            CLS_LW, CLS_SW: illegal_funct = (funct3 != 3'b010);
            CLS_BEQ: begin
                alu_ctrl      = ALU_SUB;
                illegal_funct = (funct3 != 3'b000);
            end
            default: alu_ctrl = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/multicycle_controller.sv
// Multi-cycle RV32 main controller: FETCH/DECODE/EXEC/MEM/WB sequencing with memory stalls.
// Define MULTICYCLE_CTRL_TRAP_EN to latch illegal instructions in a TRAP state until reset.
//
// state  | meaning
// FETCH  | read instruction memory, load IR and advance PC on ready
// DECODE | classify instr_i, register class and ALU op
// EXEC   | ALU operation, branch resolve, JAL PC update
// MEM    | data memory read (LW) or write (SW), waits for ready
// WB     | one-cycle register file write
// TRAP   | illegal instruction seen, outputs frozen until reset (optional)
module multicycle_controller
    import multicycle_controller_pkg::*;
#(
    parameter int ALUCTRL_W = 4
) (
    input  logic                 clk_i,
    input  logic                 rst_n,
    input  logic [31:0]          instr_i,
    input  logic                 mem_ready_i,
    input  logic                 zero_i,
    output logic                 PCWrite_o,
    output logic [1:0]           PCSrc_o,
    output logic                 IRWrite_o,
    output logic                 MemRead_o,
    output logic                 MemWrite_o,
    output logic                 IorD_o,
    output logic                 ALUsrc_o,
    output logic [1:0]           MemToReg_o,
    output logic                 RegWrite_o,
    output logic                 Branch_o,
    output logic [ALUCTRL_W-1:0] ALUControl_o,
    output logic                 illegal_o
);

    state_t     state_q, state_d;
    instr_cls_t cls_q, cls_d, cls_dec;
    logic [3:0] alu_q, alu_d, alu_dec, alu_out;
    logic       illegal_funct;
    logic       instr_illegal;
    logic       unused_instr_bits;

    assign cls_dec           = classify(instr_i[6:0]);
    assign instr_illegal     = (cls_dec == CLS_ILL) || illegal_funct;
    assign unused_instr_bits = ^{instr_i[31], instr_i[29:15], instr_i[11:7]};

    multicycle_controller_alu_decoder u_alu_decoder (
        .cls           (cls_dec),
        .funct3        (instr_i[14:12]),
        .funct7_b5     (instr_i[30]),
        .alu_ctrl      (alu_dec),
        .illegal_funct (illegal_funct)
    );

    always_ff @(posedge clk_i) begin
        if (rst_n) begin
            state_q <= S_FETCH;
            cls_q   <= CLS_R;
            alu_q   <= ALU_AND;
        end else begin
            state_q <= state_d;
            cls_q   <= cls_d;
            alu_q   <= alu_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cls_d      = cls_q;
        alu_d      = alu_q;
        PCWrite_o  = 1'b0;
        PCSrc_o    = PCSRC_INC;
        IRWrite_o  = 1'b0;
        MemRead_o  = 1'b0;
        MemWrite_o = 1'b0;
        IorD_o     = 1'b0;
        ALUsrc_o   = 1'b0;
        MemToReg_o = WB_ALU;
        RegWrite_o = 1'b0;
        Branch_o   = 1'b0;
        alu_out    = ALU_AND;
        illegal_o  = 1'b0;

        case (state_q)
            S_FETCH: begin
                MemRead_o = 1'b1;
                if (mem_ready_i) begin
                    IRWrite_o = 1'b1;
                    PCWrite_o = 1'b1;
                    state_d   = S_DECODE;
                end
            end
            S_DECODE: begin
                cls_d = cls_dec;
                alu_d = alu_dec;
                if (instr_illegal) begin
                    illegal_o = 1'b1;
`ifdef MULTICYCLE_CTRL_TRAP_EN
                    state_d   = S_TRAP;
`else
                    state_d   = S_FETCH;
`endif
                end else begin
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                alu_out = alu_q;
                case (cls_q)
                    CLS_R, CLS_LUI: state_d = S_WB;
                    CLS_I: begin
                        ALUsrc_o = 1'b1;
                        state_d  = S_WB;
                    end
                    CLS_LW, CLS_SW: begin
                        ALUsrc_o = 1'b1;
                        state_d  = S_MEM;
                    end
                    CLS_BEQ: begin
                        Branch_o = 1'b1;
                        if (zero_i) begin
                            PCWrite_o = 1'b1;
                            PCSrc_o   = PCSRC_BRANCH;
                        end
                        state_d = S_FETCH;
                    end
                    CLS_JAL: begin
                        PCWrite_o = 1'b1;
                        PCSrc_o   = PCSRC_JAL;
                        state_d   = S_WB;
                    end
                    default: state_d = S_FETCH;
                endcase
            end
            S_MEM: begin
                alu_out    = alu_q;
                IorD_o     = 1'b1;
                MemRead_o  = (cls_q == CLS_LW);
                MemWrite_o = (cls_q == CLS_SW);
                if (mem_ready_i) begin
                    state_d = (cls_q == CLS_LW) ? S_WB : S_FETCH;
                end
            end
            S_WB: begin
                alu_out    = alu_q;
                RegWrite_o = 1'b1;
                case (cls_q)
                    CLS_LW:  MemToReg_o = WB_MEM;
                    CLS_JAL: MemToReg_o = WB_PC4;
                    CLS_LUI: MemToReg_o = WB_IMM;
                    default: MemToReg_o = WB_ALU;
                endcase
                state_d = S_FETCH;
            end
`ifdef MULTICYCLE_CTRL_TRAP_EN
            S_TRAP: illegal_o = 1'b1;
`endif
            default: state_d = S_FETCH;
        endcase

        // Outputs are quiet during reset so an aborted instruction cannot write anything.
        if (rst_n) begin
            PCWrite_o  = 1'b0;
            PCSrc_o    = PCSRC_INC;
            IRWrite_o  = 1'b0;
            MemRead_o  = 1'b0;
            MemWrite_o = 1'b0;
            IorD_o     = 1'b0;
            ALUsrc_o   = 1'b0;
            MemToReg_o = WB_ALU;
            RegWrite_o = 1'b0;
            Branch_o   = 1'b0;
            alu_out    = ALU_AND;
            illegal_o  = 1'b0;
        end
    end

    assign ALUControl_o = ALUCTRL_W'(alu_out);

endmodule

// File: doc/multicycle_controller.md
Name: multicycle_controller

Overview:
- Multi-cycle successor to the single-cycle RV32 main controller.
- An FSM sequences FETCH/DECODE/EXEC/MEM/WB and drives per-state datapath enables.
- Adds I-type ALU, LUI and JAL decode, and a wider ALU op set.
- Adds a memory ready handshake so instruction and data memory may stall.
- Sits between the instruction register and the shared datapath (PC, register file, ALU, data memory).

Parameters:
- ALUCTRL_W, 4, width of ALUControl_o.
- PC_INC, 4, byte increment applied on PC advance (documentation only; the datapath adds it, selected by PCSrc_o=00).

Ports:
- clk_i  in  1  clock; all state on rising edge.
- rst_n  in  1  synchronous reset, active-high (rst_n==1 resets on the next clk_i edge).
- instr_i  in  32  current instruction from the datapath IR; valid from DECODE onward.
- mem_ready_i  in  1  memory completes the current read/write this cycle.
- zero_i  in  1  ALU zero flag, sampled in EXEC for branches.
- PCWrite_o  out  1  PC load enable.
- PCSrc_o  out  2  PC source: 00 PC+PC_INC, 01 branch target, 10 JAL target.
- IRWrite_o  out  1  IR load enable.
- MemRead_o  out  1  memory read request (fetch or load).
- MemWrite_o  out  1  memory write request.
- IorD_o  out  1  0 = instruction address, 1 = data address.
- ALUsrc_o  out  1  ALU B operand: 0 = rs2, 1 = immediate.
- MemToReg_o  out  2  writeback source: 00 ALU, 01 memory, 10 PC+4, 11 immediate (LUI).
- RegWrite_o  out  1  register file write enable.
- Branch_o  out  1  high in EXEC for a BEQ.
- ALUControl_o  out  ALUCTRL_W  ALU operation.
- illegal_o  out  1  unsupported opcode/funct detected.

Behaviour:
- States: FETCH, DECODE, EXEC, MEM, WB, plus TRAP when the optional feature is enabled. Reset state is FETCH.
- Reset: while rst_n=1, the state returns to FETCH at the edge. In the reset cycle every output is 0 (ALUControl_o=0000). Reset mid-instruction aborts with no register or memory write.
- FETCH:
  - Drive MemRead_o=1, IorD_o=0.
  - Hold while mem_ready_i=0.
  - When mem_ready_i=1, same cycle: IRWrite_o=1, PCWrite_o=1, PCSrc_o=00; next state DECODE.
- DECODE: classify instr_i[6:0] and register the class. No enables asserted.
  - 0x33 R, 0x13 I-ALU, 0x03 LW, 0x23 SW, 0x63 BEQ, 0x6F JAL, 0x37 LUI.
  - Any other opcode, or unsupported funct3/funct7, is illegal.
- EXEC:
  - R/I-ALU/LW/SW/LUI: ALU runs; ALUsrc_o=1 for I-ALU, LW and SW. Next state WB for R/I-ALU/LUI, MEM for LW/SW.
  - BEQ: Branch_o=1, ALUControl_o=0110. If zero_i=1: PCWrite_o=1, PCSrc_o=01. Next state FETCH.
  - JAL: PCWrite_o=1, PCSrc_o=10. Next state WB.
- MEM:
  - IorD_o=1. MemRead_o=1 for LW, MemWrite_o=1 for SW.
  - Hold while mem_ready_i=0.
  - On ready: LW goes to WB, SW goes to FETCH.
- WB: RegWrite_o=1 for exactly one cycle. MemToReg_o: 00 for R/I-ALU, 01 for LW, 10 for JAL, 11 for LUI. Next state FETCH.
- ALUControl_o encoding:
  - 0000 AND, 0001 OR, 0010 ADD, 0011 XOR, 0110 SUB, 0111 SLT, 1000 SLL, 1001 SRL, 1010 SRA.
  - Decoded from funct3 and funct7[5]. I-ALU never yields SUB.
  - LW/SW/JAL/LUI use ADD.
  - Held stable from EXEC through WB; 0000 in FETCH and DECODE.
- Latency with zero wait states, in cycles: BEQ 3, SW 4, R/I-ALU/LUI/JAL 4, LW 5. Each cycle of mem_ready_i=0 adds one.
- MemRead_o and MemWrite_o are never high together. RegWrite_o is never high outside WB.

Optional Feature:
- Macro: MULTICYCLE_CTRL_TRAP_EN.
- Defined: an illegal instruction in DECODE goes to TRAP. TRAP holds illegal_o=1 with all enables 0 until reset.
- Undefined: an illegal instruction is a NOP. illegal_o pulses 1 for the DECODE cycle, the FSM returns to FETCH, and no writes occur. PC was already advanced in FETCH.

Decomposition:
- Shared package holds:
  - state enum;
  - opcode constants (OP_R=0x33, OP_I=0x13, OP_LW=0x03, OP_SW=0x23, OP_BEQ=0x63, OP_JAL=0x6F, OP_LUI=0x37);
  - ALU op constants;
  - PCSrc and MemToReg encodings.
- One sub-module, alu_decoder: combinational mapping of instruction class, funct3 and funct7[5] to ALUControl_o and illegal-funct.

Test Plan:
- Reset held 3 cycles mid-LW (in MEM), then released -> all outputs 0 during reset, state FETCH afterward, no RegWrite_o pulse.
- ADD x3,x1,x2 (0x002081B3) with mem_ready_i=1 -> 4 cycles; ALUControl_o=0010 in EXEC; RegWrite_o=1, MemToReg_o=00 in cycle 4 only.
- LW (0x0000A183) with mem_ready_i low for 2 cycles in MEM -> MemRead_o/IorD_o=1 held 3 cycles; WB MemToReg_o=01; total 7 cycles.
- BEQ (0x00208463) run twice, zero_i=1 then 0 -> PCWrite_o=1, PCSrc_o=01 in EXEC only when zero_i=1; Branch_o=1, ALUControl_o=0110 both times.
- SRA x3,x1,x2 (0x4020D1B3) -> ALUControl_o=1010; SRAI with funct7=0x20 -> 1010; ADDI with funct7 bits set -> 0010.
- Opcode 0x7F -> with MULTICYCLE_CTRL_TRAP_EN: illegal_o stuck high, no enables until reset. Without it: one-cycle illegal_o pulse, then FETCH.
